// File: rtl/v_issue_ctrl.sv
// In-order vector issue controller: one instruction in flight per unit, vsetvli drains all units.
// Optional register hazard scoreboard enabled by defining V_ISSUE_SCOREBOARD_EN.
module v_issue_ctrl #(
   parameter int unsigned NUM_UNITS = 5
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           unit_sel,
   input  logic                 is_vconfig,
   input  logic [4:0]           vd,
   input  logic [4:0]           vrs1,
   input  logic [4:0]           vrs2,
   input  logic                 uses_vs1,
   input  logic                 uses_vs2,
   output logic [NUM_UNITS-1:0] iss_valid,
   input  logic [NUM_UNITS-1:0] iss_ready,
   input  logic [NUM_UNITS-1:0] unit_done,
   output logic                 cfg_we,
   output logic                 err_illegal,
   output logic                 busy
);

   localparam int unsigned SEL_W = 3;
   localparam int unsigned REG_W = 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_ISSUE = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t               state, state_nx;
   logic [NUM_UNITS-1:0] outstanding, outstanding_nx;
   logic [NUM_UNITS-1:0] iss_valid_nx;
   logic                 cfg_we_nx, err_illegal_nx, load_hold;

   logic [SEL_W-1:0]     h_unit_sel;
   logic                 h_is_vconfig;
   logic [REG_W-1:0]     h_vd, h_vrs1, h_vrs2;
   logic                 h_uses_vs1, h_uses_vs2;

   logic [NUM_UNITS-1:0] sel_onehot;
   logic                 sel_illegal, target_busy, hazard, stall, issue_hs;

   assign sel_onehot  = NUM_UNITS'(1) << h_unit_sel;
   assign sel_illegal = 32'(h_unit_sel) >= NUM_UNITS;
   assign target_busy = |(outstanding & sel_onehot);
   assign stall       = target_busy | hazard;
   assign issue_hs    = (state == S_ISSUE) && |(iss_ready & sel_onehot);

`ifdef V_ISSUE_SCOREBOARD_EN
   // Per-unit destination record; compared against the held instruction's operands.
   logic [NUM_UNITS-1:0] hz_bits;
   for (genvar u = 0; u < NUM_UNITS; u++) begin : g_sb
      logic [REG_W-1:0] vd_q;
      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst) begin
            vd_q <= '0;
         end else if (issue_hs && sel_onehot[u]) begin
            vd_q <= h_vd;
         end
      end
      assign hz_bits[u] = outstanding[u] &&
                          ((vd_q == h_vd) ||
                           (h_uses_vs1 && (vd_q == h_vrs1)) ||
                           (h_uses_vs2 && (vd_q == h_vrs2)));
   end
   assign hazard = |hz_bits;
`else
   logic unused_hold;
   assign hazard      = 1'b0;
   assign unused_hold = ^{h_vd, h_vrs1, h_vrs2, h_uses_vs1, h_uses_vs2};
`endif

   // Next-state and registered-output decode.
   always_comb begin
      state_nx       = state;
      outstanding_nx = outstanding & ~unit_done;
      iss_valid_nx   = '0;
      cfg_we_nx      = 1'b0;
      err_illegal_nx = 1'b0;
      load_hold      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (in_valid) begin
               load_hold = 1'b1;
               state_nx  = S_CHECK;
            end
         end
         S_CHECK: begin
            if (h_is_vconfig) begin
               state_nx = S_DRAIN;
            end else if (sel_illegal) begin
               err_illegal_nx = 1'b1;
               state_nx       = S_IDLE;
            end else if (!stall) begin
               iss_valid_nx = sel_onehot;
               state_nx     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (issue_hs) begin
               outstanding_nx = outstanding_nx | sel_onehot;
               state_nx       = S_IDLE;
            end else begin
               iss_valid_nx = sel_onehot;
            end
         end
         S_DRAIN: begin
            if (outstanding == '0) begin
               cfg_we_nx = 1'b1;
               state_nx  = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state        <= S_IDLE;
         outstanding  <= '0;
         iss_valid    <= '0;
         cfg_we       <= 1'b0;
         err_illegal  <= 1'b0;
         in_ready     <= 1'b1;
         busy         <= 1'b0;
         h_unit_sel   <= '0;
         h_is_vconfig <= 1'b0;
         h_vd         <= '0;
         h_vrs1       <= '0;
         h_vrs2       <= '0;
         h_uses_vs1   <= 1'b0;
         h_uses_vs2   <= 1'b0;
      end else begin
         state       <= state_nx;
         outstanding <= outstanding_nx;
         iss_valid   <= iss_valid_nx;
         cfg_we      <= cfg_we_nx;
         err_illegal <= err_illegal_nx;
         in_ready    <= (state_nx == S_IDLE);
         busy        <= (state_nx != S_IDLE) || (outstanding_nx != '0);
         if (load_hold) begin
            h_unit_sel   <= unit_sel;
            h_is_vconfig <= is_vconfig;
            h_vd         <= vd;
            h_vrs1       <= vrs1;
            h_vrs2       <= vrs2;
            h_uses_vs1   <= uses_vs1;
            h_uses_vs2   <= uses_vs2;
         end
      end
   end

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Self-checking bench for v_issue_ctrl; issue order checked through an expected-issue queue.
// Hazard expectations follow V_ISSUE_SCOREBOARD_EN.
module tb_v_issue_ctrl;

   localparam int unsigned NU = 5;

   logic          clk = 1'b0;
   logic          nrst;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    unit_sel;
   logic          is_vconfig;
   logic [4:0]    vd, vrs1, vrs2;
   logic          uses_vs1, uses_vs2;
   logic [NU-1:0] iss_valid;
   logic [NU-1:0] iss_ready;
   logic [NU-1:0] unit_done;
   logic          cfg_we;
   logic          err_illegal;
   logic          busy;

   int            vectors = 0;
   int            miscompares = 0;
   logic [NU-1:0] exp_q[$];
   logic [NU-1:0] mon_exp;

   v_issue_ctrl #(.NUM_UNITS(NU)) dut (
      .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
      .unit_sel(unit_sel), .is_vconfig(is_vconfig), .vd(vd), .vrs1(vrs1), .vrs2(vrs2),
      .uses_vs1(uses_vs1), .uses_vs2(uses_vs2), .iss_valid(iss_valid),
      .iss_ready(iss_ready), .unit_done(unit_done), .cfg_we(cfg_we),
      .err_illegal(err_illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   // Every issue handshake must match the oldest expected issue.
   always @(negedge clk) begin
      if (nrst && ((iss_valid & iss_ready) != '0)) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL issue_unexpected got=%b", iss_valid);
         end else begin
            mon_exp = exp_q.pop_front();
            if (iss_valid !== mon_exp) begin
               miscompares++;
               $display("FAIL issue_order got=%b exp=%b", iss_valid, mon_exp);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_done(input logic [NU-1:0] mask);
      unit_done = mask;
      step();
      unit_done = '0;
   endtask

   // Presents one instruction; returns 1ns after the accepting edge.
   task automatic send(input logic [2:0] sel, input logic cfg, input logic [4:0] d,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (!in_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL send_timeout in_ready=%b exp=1", in_ready);
      end
      if (!cfg && (32'(sel) < NU)) exp_q.push_back(NU'(1) << sel);
      in_valid = 1'b1; unit_sel = sel; is_vconfig = cfg;
      vd = d; vrs1 = r1; vrs2 = r2; uses_vs1 = u1; uses_vs2 = u2;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      vectors += 5;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (iss_valid !== '0) begin miscompares++; $display("FAIL rst_iss_valid got=%b exp=0", iss_valid); end
      if (cfg_we !== 1'b0) begin miscompares++; $display("FAIL rst_cfg_we got=%b exp=0", cfg_we); end
      if (err_illegal !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%b exp=0", err_illegal); end
   endtask

   task automatic test_alu_latency();
      send(3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
      vectors += 3;
      if (iss_valid !== 5'b00000) begin miscompares++; $display("FAIL lat_n1 got=%b exp=00000", iss_valid); end
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL lat_in_ready got=%b exp=0", in_ready); end
      if (busy !== 1'b1) begin miscompares++; $display("FAIL lat_busy got=%b exp=1", busy); end
      step();
      vectors++;
      if (iss_valid !== 5'b00001) begin miscompares++; $display("FAIL lat_n2 got=%b exp=00001", iss_valid); end
      step();
      vectors += 2;
      if (iss_valid !== 5'b00000) begin miscompares++; $display("FAIL lat_one_cycle got=%b exp=00000", iss_valid); end
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL lat_ready_back got=%b exp=1", in_ready); end
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (busy !== 1'b1) begin miscompares++; $display("FAIL lat_busy_hold got=%b exp=1", busy); end
      end
      pulse_done(5'b00001);
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL lat_busy_clear got=%b exp=0", busy); end
   endtask

   task automatic test_illegal();
      logic [2:0] sels [2];
      sels[0] = 3'd6;
      sels[1] = 3'd5;
      for (int k = 0; k < 2; k++) begin
         send(sels[k], 1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
         vectors++;
         if (err_illegal !== 1'b0) begin miscompares++; $display("FAIL ill_early got=%b exp=0", err_illegal); end
         step();
         vectors += 3;
         if (err_illegal !== 1'b1) begin miscompares++; $display("FAIL ill_pulse sel=%0d got=%b exp=1", sels[k], err_illegal); end
         if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ill_in_ready got=%b exp=1", in_ready); end
         if (iss_valid !== '0) begin miscompares++; $display("FAIL ill_iss got=%b exp=0", iss_valid); end
         step();
         vectors += 2;
         if (err_illegal !== 1'b0) begin miscompares++; $display("FAIL ill_single got=%b exp=0", err_illegal); end
         if (busy !== 1'b0) begin miscompares++; $display("FAIL ill_busy got=%b exp=0", busy); end
      end
      // Highest legal index issues normally.
      send(3'd4, 1'b0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
      step();
      vectors++;
      if (iss_valid !== 5'b10000) begin miscompares++; $display("FAIL vred_issue got=%b exp=10000", iss_valid); end
      step();
      pulse_done(5'b10000);
   endtask

   task automatic test_issue_stall();
      iss_ready = 5'b00000;
      send(3'd2, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         vectors++;
         if (iss_valid !== 5'b00100) begin miscompares++; $display("FAIL stall_hold cyc=%0d got=%b exp=00100", i, iss_valid); end
      end
      iss_ready = 5'b00100;
      step();
      vectors++;
      if (iss_valid !== 5'b00000) begin miscompares++; $display("FAIL stall_drop got=%b exp=00000", iss_valid); end
      iss_ready = 5'b11111;
      pulse_done(5'b00100);
   endtask

   task automatic test_target_busy();
      send(3'd1, 1'b0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
      step(); step();
      send(3'd1, 1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (iss_valid !== '0) begin miscompares++; $display("FAIL tgt_stall got=%b exp=0", iss_valid); end
      end
      pulse_done(5'b00010);
      vectors++;
      if (iss_valid !== '0) begin miscompares++; $display("FAIL tgt_release_early got=%b exp=0", iss_valid); end
      step();
      vectors++;
      if (iss_valid !== 5'b00010) begin miscompares++; $display("FAIL tgt_release got=%b exp=00010", iss_valid); end
      step();
      pulse_done(5'b00010);
   endtask

   task automatic test_hazard();
      send(3'd1, 1'b0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
      step(); step();
      // vrs1 matches but is not a vector read: no hazard.
      send(3'd0, 1'b0, 5'd1, 5'd4, 5'd2, 1'b0, 1'b1);
      step();
      vectors++;
      if (iss_valid !== 5'b00001) begin miscompares++; $display("FAIL hz_none got=%b exp=00001", iss_valid); end
      step();
      pulse_done(5'b00001);
      send(3'd0, 1'b0, 5'd5, 5'd0, 5'd4, 1'b0, 1'b1);
`ifdef V_ISSUE_SCOREBOARD_EN
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (iss_valid !== '0) begin miscompares++; $display("FAIL hz_raw_stall got=%b exp=0", iss_valid); end
      end
      pulse_done(5'b00010);
      vectors++;
      if (iss_valid !== '0) begin miscompares++; $display("FAIL hz_raw_early got=%b exp=0", iss_valid); end
      step();
      vectors++;
      if (iss_valid !== 5'b00001) begin miscompares++; $display("FAIL hz_raw_release got=%b exp=00001", iss_valid); end
      step();
      pulse_done(5'b00001);
`else
      step();
      vectors++;
      if (iss_valid !== 5'b00001) begin miscompares++; $display("FAIL hz_off_issue got=%b exp=00001", iss_valid); end
      step();
      pulse_done(5'b00011);
`endif
   endtask

   task automatic test_vconfig_drain();
      int pulses;
      send(3'd2, 1'b0, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0);
      step(); step();
      send(3'd3, 1'b0, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0);
      step(); step();
      send(3'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (cfg_we === 1'b1) pulses++;
      end
      pulse_done(5'b00100);
      if (cfg_we === 1'b1) pulses++;
      step();
      if (cfg_we === 1'b1) pulses++;
      pulse_done(5'b01000);
      if (cfg_we === 1'b1) pulses++;
      vectors += 2;
      if (pulses != 0) begin miscompares++; $display("FAIL drain_early got=%0d exp=0", pulses); end
      if (iss_valid !== '0) begin miscompares++; $display("FAIL drain_iss got=%b exp=0", iss_valid); end
      step();
      vectors += 2;
      if (cfg_we !== 1'b1) begin miscompares++; $display("FAIL drain_cfg_we got=%b exp=1", cfg_we); end
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL drain_ready got=%b exp=1", in_ready); end
      step();
      vectors++;
      if (cfg_we !== 1'b0) begin miscompares++; $display("FAIL drain_single got=%b exp=0", cfg_we); end
      // Nothing outstanding: cfg_we two cycles after the accepting edge.
      send(3'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      step();
      vectors++;
      if (cfg_we !== 1'b0) begin miscompares++; $display("FAIL cfg_idle_early got=%b exp=0", cfg_we); end
      step();
      vectors++;
      if (cfg_we !== 1'b1) begin miscompares++; $display("FAIL cfg_idle got=%b exp=1", cfg_we); end
      step();
   endtask

   task automatic test_reset_drain();
      int pulses;
      send(3'd4, 1'b0, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0);
      step(); step();
      send(3'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      step(); step();
      nrst = 1'b0;
      #1;
      vectors += 4;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rd_in_ready got=%b exp=1", in_ready); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_busy got=%b exp=0", busy); end
      if (cfg_we !== 1'b0) begin miscompares++; $display("FAIL rd_cfg_we got=%b exp=0", cfg_we); end
      if (iss_valid !== '0) begin miscompares++; $display("FAIL rd_iss got=%b exp=0", iss_valid); end
      step(); step();
      nrst = 1'b1;
      pulses = 0;
      pulse_done(5'b10000);
      for (int i = 0; i < 5; i++) begin
         step();
         if (cfg_we === 1'b1 || iss_valid !== '0) pulses++;
      end
      vectors += 2;
      if (pulses != 0) begin miscompares++; $display("FAIL rd_no_pulse got=%0d exp=0", pulses); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL rd_busy_after got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      for (int u = 0; u < 5; u++) begin
         send(3'(u), 1'b0, 5'(16 + u), 5'd0, 5'd0, 1'b0, 1'b0);
      end
      step(); step();
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy got=%b exp=1", busy); end
      pulse_done(5'b11111);
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_all_done got=%b exp=0", busy); end
   endtask

   initial begin
      nrst = 1'b0; in_valid = 1'b0; unit_sel = '0; is_vconfig = 1'b0;
      vd = '0; vrs1 = '0; vrs2 = '0; uses_vs1 = 1'b0; uses_vs2 = 1'b0;
      iss_ready = 5'b11111; unit_done = '0;
      step(); step();
      nrst = 1'b1;
      step();
      test_reset();
      test_alu_latency();
      test_illegal();
      test_issue_stall();
      test_target_busy();
      test_hazard();
      test_vconfig_drain();
      test_reset_drain();
      test_back_to_back();
      step(); step();
      vectors++;
      if (exp_q.size() != 0) begin miscompares++; $display("FAIL pending_issues got=%0d exp=0", exp_q.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
